// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: the 2-bit counter encoding,
// the default table size and the table index width.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_state_e;

    localparam int DEFAULT_ENTRIES = 16;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Saturating 2-bit history counter step: taken moves toward STRONG_T,
// not taken moves toward STRONG_NT; both ends hold.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_state_e state_i,
    input  logic       taken_i,
    output ctr_state_e next_o
);

    always_comb begin
        next_o = state_i;
        unique case (state_i)
            STRONG_NT: next_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   next_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    next_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  next_o = taken_i ? STRONG_T : WEAK_T;
            default:   next_o = state_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit counters indexed by PC word
// address, looked up in ID and trained one cycle after EX resolution.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_instr_id,
    input  logic [31:0] pc_id,
    output logic        branch_pred,
    input  logic        branch_instr_exe,
    input  logic [31:0] pc_exe,
    input  logic        is_zero,
    input  logic        branch_pred_exe,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispredict_cnt
);

    localparam int IDX_W = idx_width(ENTRIES);

    // branch_instr_exe acts as a valid with no ready: a resolution is consumed
    // in every cycle it is high and cannot be back-pressured.
    ctr_state_e           table_q [ENTRIES];
    logic                 upd_vld_q;
    logic [IDX_W-1:0]     upd_idx_q;
    logic                 upd_taken_q;
    ctr_state_e           upd_next;
    logic [15:0]          branch_cnt_q, branch_cnt_d;
    logic [15:0]          mispredict_cnt_q, mispredict_cnt_d;
    logic [IDX_W-1:0]     lookup_idx;
    logic [1:0]           lookup_state;
    logic                 unused_pc_bits;

    assign lookup_idx     = pc_id[IDX_W+1:2];
    assign lookup_state   = table_q[lookup_idx];
    assign branch_pred    = lookup_state[1] & branch_instr_id;
    assign unused_pc_bits = ^{pc_id[31:IDX_W+2], pc_id[1:0],
                              pc_exe[31:IDX_W+2], pc_exe[1:0]};

    sat_counter2 u_sat_counter2 (
        .state_i (table_q[upd_idx_q]),
        .taken_i (upd_taken_q),
        .next_o  (upd_next)
    );

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (branch_instr_exe) begin
            if (branch_cnt_q != STAT_MAX)
                branch_cnt_d = branch_cnt_q + 16'd1;
            if ((branch_pred_exe != is_zero) && (mispredict_cnt_q != STAT_MAX))
                mispredict_cnt_d = mispredict_cnt_q + 16'd1;
        end
    end

    // The table write lags resolution by one edge; a lookup in the write
    // cycle deliberately sees the old counter (no bypass).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++)
                table_q[i] <= WEAK_NT;
            upd_vld_q        <= 1'b0;
            upd_idx_q        <= '0;
            upd_taken_q      <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (upd_vld_q)
                table_q[upd_idx_q] <= upd_next;
            upd_vld_q        <= branch_instr_exe;
            upd_idx_q        <= pc_exe[IDX_W+1:2];
            upd_taken_q      <= is_zero;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule
